// File: rtl/seg_scan_mux_pkg.sv
// Shared definitions for the display path: blank/zero segment patterns,
// scan FSM state encoding, digit count and the seven-segment decode table
// used by upstream stages and benches.
package seg_scan_mux_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_ZERO  = 8'hC0;
  localparam int         NDIG      = 4;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // Active-low common-anode patterns, bit7=dp ... bit0=a.
  function automatic logic [7:0] seg7_decode(input logic [3:0] val);
    logic [7:0] pat;
    case (val)
      4'd0:    pat = 8'hC0;
      4'd1:    pat = 8'hF9;
      4'd2:    pat = 8'hA4;
      4'd3:    pat = 8'hB0;
      4'd4:    pat = 8'h99;
      4'd5:    pat = 8'h92;
      4'd6:    pat = 8'h82;
      4'd7:    pat = 8'hF8;
      4'd8:    pat = 8'h80;
      4'd9:    pat = 8'h90;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_scan_mux.sv
// Four-digit seven-segment scan multiplexer.
//
//   state | meaning
//   BLANK | all anodes off for BLANK_CYC cycles before the next digit
//   SHOW  | digit idx driven on the shared bus for SCAN_DIV cycles
//
// Ports:
//   clock       system clock, rising edge
//   rst         synchronous active-high reset
//   dig0..dig3  active-low segment patterns, digit 0 leftmost
//   lzb_en      hide digit 0 when it shows "0"
//   seg_out     shared segment bus, active-low
//   an_out      one-hot active-low anode select
//   frame_tick  one-cycle pulse after the last SHOW cycle of digit 3
module seg_scan_mux #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [7:0] dig0,
  input  logic [7:0] dig1,
  input  logic [7:0] dig2,
  input  logic [7:0] dig3,
  input  logic       lzb_en,
  output logic [7:0] seg_out,
  output logic [3:0] an_out,
  output logic       frame_tick
);

  import seg_scan_mux_pkg::*;

  localparam int TMAX    = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int TW      = $clog2(TMAX + 1);
  localparam bit HAS_GAP = (BLANK_CYC > 0);

  localparam logic [TW-1:0] SHOW_LAST  = TW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] BLANK_LAST = HAS_GAP ? TW'(BLANK_CYC - 1) : '0;

  scan_state_e   state;
  logic [1:0]    idx;
  logic [TW-1:0] timer;
  logic [7:0]    snap [NDIG];
  logic          snap_lzb;

  logic [7:0] din [NDIG];
  logic [7:0] cur [NDIG];
  logic       cur_lzb;
  logic       load;
  logic       show_end;
  logic [1:0] idx_nxt;
  logic [1:0] show_idx;
  logic [7:0] seg_sel;

  // The snapshot is taken at the first cycle of a frame. The digit about to
  // be lit reads through 'cur', so a snapshot taken on the same edge that
  // lights digit 0 (BLANK_CYC of 0 or 1) still shows the fresh value.
  always_comb begin
    din[0]   = dig0;
    din[1]   = dig1;
    din[2]   = dig2;
    din[3]   = dig3;
    show_end = (state == SHOW) && (timer == SHOW_LAST);
    idx_nxt  = idx + 2'd1;
    load     = ((state == BLANK) && (idx == 2'd0) && (timer == '0)) ||
               (!HAS_GAP && show_end && (idx == 2'd3));
    for (int i = 0; i < NDIG; i++) begin
      cur[i] = load ? din[i] : snap[i];
    end
    cur_lzb  = load ? lzb_en : snap_lzb;
    // Leaving BLANK lights the current idx; SHOW->SHOW lights the next one.
    show_idx = (state == BLANK) ? idx : idx_nxt;
    seg_sel  = cur[show_idx];
    if ((show_idx == 2'd0) && cur_lzb && (cur[0] == SEG_ZERO)) begin
      seg_sel = SEG_BLANK;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= BLANK;
      idx        <= 2'd0;
      timer      <= '0;
      seg_out    <= SEG_BLANK;
      an_out     <= 4'hF;
      frame_tick <= 1'b0;
      snap_lzb   <= 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        snap[i] <= SEG_BLANK;
      end
    end else begin
      frame_tick <= show_end && (idx == 2'd3);
      if (load) begin
        snap_lzb <= lzb_en;
        for (int i = 0; i < NDIG; i++) begin
          snap[i] <= din[i];
        end
      end
      case (state)
        BLANK: begin
          if (!HAS_GAP || (timer == BLANK_LAST)) begin
            state   <= SHOW;
            timer   <= '0;
            an_out  <= ~(4'b0001 << idx);
            seg_out <= seg_sel;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        SHOW: begin
          if (show_end) begin
            idx   <= idx_nxt;
            timer <= '0;
            if (HAS_GAP) begin
              state   <= BLANK;
              an_out  <= 4'hF;
              seg_out <= SEG_BLANK;
            end else begin
              // Single-edge anode hand-over: one bit rises as the next falls.
              an_out  <= ~(4'b0001 << idx_nxt);
              seg_out <= seg_sel;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= BLANK;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;

  logic       clock;
  logic       rst;
  logic [7:0] dig0, dig1, dig2, dig3;
  logic       lzb_en;
  logic [7:0] seg_out, seg0;
  logic [3:0] an_out, an0;
  logic       frame_tick, tick0;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;
  logic mon_en = 1'b0;

  seg_scan_mux #(.SCAN_DIV(4), .BLANK_CYC(2)) dut (
    .clock(clock), .rst(rst),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .lzb_en(lzb_en),
    .seg_out(seg_out), .an_out(an_out), .frame_tick(frame_tick)
  );

  seg_scan_mux #(.SCAN_DIV(4), .BLANK_CYC(0)) dut0 (
    .clock(clock), .rst(rst),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .lzb_en(lzb_en),
    .seg_out(seg0), .an_out(an0), .frame_tick(tick0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, ecnt);
      $error("check %s", tag);
    end
  endtask

  // Advance to just after edge n (counted from the last reset edge).
  task automatic goto(input int n);
    while (ecnt < n) begin
      @(posedge clock);
      ecnt++;
    end
    #1;
  endtask

  // Anode one-hot invariant on both builds, sampled away from the edge.
  always @(negedge clock) begin
    if (mon_en) begin
      total++;
      assert (($countones(~an_out) <= 1) && ($countones(~an0) <= 1)) else begin
        bad++;
        $display("FAIL onehot observed=%h/%h expected=at most one low", an_out, an0);
        $error("check onehot");
      end
    end
  end

  initial begin
    rst = 1'b1;
    dig0 = 8'hF9; dig1 = 8'hA4; dig2 = 8'hC0; dig3 = 8'hC0;
    lzb_en = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    ecnt = 0;
    chk("rst_seg", seg_out, 8'hFF);
    chk("rst_an", {4'h0, an_out}, 8'h0F);
    chk("rst_tick", {7'd0, frame_tick}, 8'h00);
    chk("rst_an0", {4'h0, an0}, 8'h0F);
    rst = 1'b0;
    mon_en = 1'b1;

    // Scan order, gap build (period 24) and no-gap build (period 16).
    goto(1);
    chk("gap1_an", {4'h0, an_out}, 8'h0F);
    chk("ng_first_an", {4'h0, an0}, 8'h0E);
    chk("ng_first_seg", seg0, 8'hF9);
    goto(2);
    chk("d0_an", {4'h0, an_out}, 8'h0E);
    chk("d0_seg", seg_out, 8'hF9);
    goto(4);
    chk("ng_d0_hold", {4'h0, an0}, 8'h0E);
    goto(5);
    chk("d0_last", {4'h0, an_out}, 8'h0E);
    chk("ng_d1_an", {4'h0, an0}, 8'h0D);
    chk("ng_d1_seg", seg0, 8'hA4);
    goto(6);
    chk("gap_an", {4'h0, an_out}, 8'h0F);
    chk("gap_seg", seg_out, 8'hFF);
    goto(8);
    chk("d1_an", {4'h0, an_out}, 8'h0D);
    chk("d1_seg", seg_out, 8'hA4);
    goto(14);
    chk("d2_an", {4'h0, an_out}, 8'h0B);
    chk("d2_seg", seg_out, 8'hC0);
    goto(17);
    chk("ng_tick", {7'd0, tick0}, 8'h01);
    chk("ng_wrap_an", {4'h0, an0}, 8'h0E);
    goto(20);
    chk("d3_an", {4'h0, an_out}, 8'h07);
    chk("d3_seg", seg_out, 8'hC0);
    chk("tick_lo", {7'd0, frame_tick}, 8'h00);
    goto(24);
    chk("tick_hi", {7'd0, frame_tick}, 8'h01);
    chk("tick_an", {4'h0, an_out}, 8'h0F);
    dig3 = 8'h90;
    goto(25);
    chk("tick_one", {7'd0, frame_tick}, 8'h00);

    // No tearing: dig3 changes while idx=1 of frame 2.
    goto(32);
    chk("f2_d1_an", {4'h0, an_out}, 8'h0D);
    dig3 = 8'h80;
    goto(33);
    chk("ng_tick2", {7'd0, tick0}, 8'h01);
    goto(44);
    chk("f2_d3_an", {4'h0, an_out}, 8'h07);
    chk("f2_d3_seg", seg_out, 8'h90);
    goto(47);
    chk("tick_pre", {7'd0, frame_tick}, 8'h00);
    goto(48);
    chk("tick_f2", {7'd0, frame_tick}, 8'h01);
    goto(68);
    chk("f3_d3_seg", seg_out, 8'h80);

    // Leading-zero blank.
    lzb_en = 1'b1; dig0 = 8'hC0; dig1 = 8'h90;
    goto(72);
    chk("tick_f3", {7'd0, frame_tick}, 8'h01);
    goto(74);
    chk("lzb_an", {4'h0, an_out}, 8'h0E);
    chk("lzb_seg", seg_out, 8'hFF);
    goto(80);
    chk("lzb_d1_an", {4'h0, an_out}, 8'h0D);
    chk("lzb_d1_seg", seg_out, 8'h90);
    lzb_en = 1'b0;
    goto(96);
    chk("tick_f4", {7'd0, frame_tick}, 8'h01);
    goto(98);
    chk("nolzb_an", {4'h0, an_out}, 8'h0E);
    chk("nolzb_seg", seg_out, 8'hC0);

    // Mid-frame reset during idx 2.
    goto(110);
    chk("mid_d2_an", {4'h0, an_out}, 8'h0B);
    rst = 1'b1;
    dig0 = 8'hA4;
    goto(111);
    chk("mrst_an", {4'h0, an_out}, 8'h0F);
    chk("mrst_seg", seg_out, 8'hFF);
    chk("mrst_an0", {4'h0, an0}, 8'h0F);
    rst = 1'b0;
    goto(112);
    chk("mrst_gap", {4'h0, an_out}, 8'h0F);
    chk("mrst_ng_an", {4'h0, an0}, 8'h0E);
    chk("mrst_ng_seg", seg0, 8'hA4);
    goto(113);
    chk("mrst_d0_an", {4'h0, an_out}, 8'h0E);
    chk("mrst_d0_seg", seg_out, 8'hA4);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
